lc3_mem_ctrl: RTL
=================

Name: lc3_mem_ctrl

Overview:
Parametrised memory controller for the LC-3 datapath. It sits on the shared 16-bit bus and owns MAR, MDR, a word-addressed RAM, and the keyboard/display device registers.
It executes one memory or MMIO access per MIO_EN assertion, with configurable wait states, and signals completion with a one-cycle rdy qualifier for the microsequencer.

Parameters:
MEM_AW, 12, RAM holds 2^MEM_AW words; RAM index = MAR[MEM_AW-1:0], so higher addresses alias.
WAIT_STATES, 4, extra cycles before a RAM access completes (0..255).
KBSR_ADDR, 16'hFE00, keyboard status register address.
KBDR_ADDR, 16'hFE02, keyboard data register address.
DSR_ADDR, 16'hFE04, display status register address.
DDR_ADDR, 16'hFE06, display data register address.

Ports:
clk  in  1  clock
arst_n  in  1  reset: asynchronous, active-low
bus  inout  16  shared datapath bus
ld_mar  in  1  MAR <= bus at clk edge
ld_mdr  in  1  load MDR; source selected by mio_en
gate_mdr  in  1  drive MDR onto bus
mio_en  in  1  request/hold memory access; also selects the MDR source
rw  in  1  0 = read, 1 = write (sampled during the access)
rdy  out  1  access completes at this clk edge
kbd_data  in  8  keyboard character
kbd_valid  in  1  one-cycle strobe: new character present
disp_data  out  8  character to display
disp_valid  out  1  display character pending
disp_ready  in  1  display consumes the character while disp_valid is high
kbd_int  out  1  keyboard interrupt request

Behaviour:
- Reset values: MAR=0, MDR=0, state IDLE, rdy=0, KBSR=0, KBDR=0, disp_valid=0, disp_data=0, bus released, kbd_int=0. RAM contents are not reset.
- Bus drive: only when gate_mdr=1, value MDR; otherwise high-Z.
- Register loads:
  - ld_mar=1: MAR <= bus.
  - ld_mdr=1 with mio_en=0: MDR <= bus.
  - ld_mdr=1 with mio_en=1: MDR loads only at the completion edge of a read (rdy=1), with the read data.
- Address decode from MAR: exact match on one of the four MMIO addresses selects MMIO; everything else selects RAM.
- FSM states IDLE, WAIT, DONE:
  - IDLE, mio_en=1, RAM, WAIT_STATES>0: go to WAIT, counter <= WAIT_STATES-1, rdy=0.
  - IDLE, mio_en=1, and either MMIO or WAIT_STATES=0: rdy=1 combinationally in that same cycle; access completes at the edge; go to DONE.
  - WAIT: rdy=1 when counter==0; access completes at the edge; go to DONE. Otherwise decrement counter.
  - WAIT with mio_en dropped: abort; no write, no MDR load, no side effects; go to IDLE.
  - DONE: rdy=0. Return to IDLE when mio_en=0, which enforces one access per assertion.
- RAM latency: rdy is high in cycle WAIT_STATES+1 counted from the first mio_en cycle. MMIO latency is always 1 cycle.
- Completion effects:
  - Read: MDR <= data, if ld_mdr is also asserted.
  - RAM write: RAM[MAR[MEM_AW-1:0]] <= MDR.
- MMIO read data (unused bits read 0):
  - KBSR = {ready, ie, 14'b0}.
  - KBDR = {8'b0, KBDR}.
  - DSR = {~disp_valid, 15'b0}.
  - DDR = {8'b0, disp_data}.
- MMIO writes:
  - KBSR: only bit 14 is written.
  - KBDR, DSR: ignored.
  - DDR: disp_data <= MDR[7:0], disp_valid <= 1.
- Keyboard:
  - kbd_valid: KBDR <= kbd_data, KBSR[15] <= 1. Overrun overwrites KBDR.
  - Completed KBDR read clears KBSR[15].
  - kbd_valid in the same cycle as a KBDR read completion: the read returns the old KBDR; the new character is stored and KBSR[15] stays 1.
- Display:
  - disp_valid clears on the edge where disp_ready=1.
  - A DDR write completing in the same cycle as disp_ready: new data is stored and disp_valid stays 1.
  - A DDR write while disp_valid=1 overwrites disp_data.
- Reset asserted mid-access: the access is abandoned with no RAM write.

Optional Feature:
LC3_MEM_CTRL_KBD_INT_EN
- Defined: KBSR[14] is writable; kbd_int = KBSR[15] & KBSR[14], registered, with 1-cycle lag.
- Undefined: KBSR[14] reads 0 and ignores writes; kbd_int is tied 0.

Test Plan:
- WAIT_STATES=4: MAR=0x3000, MDR=0x1234, mio_en=rw=1 held -> rdy=1 only in cycle 5; RAM[0x000]=0x1234. Then read with ld_mdr -> MDR=0x1234 on the rdy edge; gate_mdr puts 0x1234 on the bus.
- WAIT_STATES=0, MEM_AW=12: write 0xBEEF at 0x3005; read 0x0005 -> rdy in cycle 1, MDR=0xBEEF (aliasing). mio_en held 3 more cycles -> rdy stays 0 and no second access.
- kbd_data=0x41, kbd_valid pulse; read KBSR -> 0x8000; read KBDR -> 0x0041; read KBSR again -> 0x0000. kbd_valid coincident with the KBDR read -> read returns the old value and KBSR[15]=1.
- Write 0x0058 to DDR with disp_ready=0 -> disp_valid=1, disp_data=0x58, DSR reads 0x0000. Pulse disp_ready -> disp_valid=0, DSR reads 0x8000.
- WAIT_STATES=4 write in progress; drop mio_en in cycle 2 -> RAM unchanged, FSM in IDLE. Repeat with arst_n low in cycle 3 -> RAM unchanged; MAR, MDR, rdy all 0.
- With LC3_MEM_CTRL_KBD_INT_EN: write 0x4000 to KBSR, then kbd_valid -> kbd_int=1 the next cycle; KBDR read -> kbd_int=0. Without the macro: KBSR reads 0x8000 and kbd_int stays 0.

Source files
------------

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: MAR/MDR, word RAM with wait states, keyboard/display MMIO.
// Optional keyboard interrupt enable: define LC3_MEM_CTRL_KBD_INT_EN.
module lc3_mem_ctrl #(
  parameter int          MEM_AW      = 12,
  parameter int          WAIT_STATES = 4,
  parameter logic [15:0] KBSR_ADDR   = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR   = 16'hFE02,
  parameter logic [15:0] DSR_ADDR    = 16'hFE04,
  parameter logic [15:0] DDR_ADDR    = 16'hFE06
) (
  input  logic        clk,
  input  logic        arst_n,
  inout  wire  [15:0] io_bus,
  input  logic        i_ld_mar,
  input  logic        i_ld_mdr,
  input  logic        i_gate_mdr,
  input  logic        i_mio_en,
  input  logic        i_rw,
  output logic        o_rdy,
  input  logic [7:0]  i_kbd_data,
  input  logic        i_kbd_valid,
  output logic [7:0]  o_disp_data,
  output logic        o_disp_valid,
  input  logic        i_disp_ready,
  output logic        o_kbd_int
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic       WS_ZERO = (WAIT_STATES == 0);
  localparam logic [7:0] WS_M1   = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;

  logic [15:0] r_mar;
  logic [15:0] r_mdr;
  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_kb_ready;
  logic [7:0]  r_kbdr;
  logic [7:0]  r_disp_data;
  logic        r_disp_valid;
  logic [15:0] r_ram [0:(1<<MEM_AW)-1];

  logic              w_sel_kbsr;
  logic              w_sel_kbdr;
  logic              w_sel_dsr;
  logic              w_sel_ddr;
  logic              w_is_mmio;
  logic              w_rdy;
  logic              w_rd_done;
  logic              w_wr_done;
  logic              w_ram_we;
  logic              w_kb_ie;
  logic [MEM_AW-1:0] w_ram_idx;
  logic [15:0]       w_ram_rd;
  logic [15:0]       w_rd_data;

  assign w_sel_kbsr = (r_mar == KBSR_ADDR);
  assign w_sel_kbdr = (r_mar == KBDR_ADDR);
  assign w_sel_dsr  = (r_mar == DSR_ADDR);
  assign w_sel_ddr  = (r_mar == DDR_ADDR);
  assign w_is_mmio  = w_sel_kbsr | w_sel_kbdr | w_sel_dsr | w_sel_ddr;

  // Completion is combinational so MMIO and zero-wait RAM finish in the request cycle;
  // gating with arst_n keeps an access from completing while reset is held.
  always_comb begin
    w_rdy = 1'b0;
    if (arst_n && i_mio_en) begin
      case (r_state)
        S_IDLE:  w_rdy = w_is_mmio | WS_ZERO;
        S_WAIT:  w_rdy = (r_cnt == 8'd0);
        default: w_rdy = 1'b0;
      endcase
    end
  end

  assign o_rdy     = w_rdy;
  assign w_rd_done = w_rdy & ~i_rw;
  assign w_wr_done = w_rdy & i_rw;
  assign w_ram_we  = w_wr_done & ~w_is_mmio;
  assign w_ram_idx = r_mar[MEM_AW-1:0];
  assign w_ram_rd  = r_ram[w_ram_idx];

  always_comb begin
    w_rd_data = w_ram_rd;
    if (w_sel_kbsr)
      w_rd_data = {r_kb_ready, w_kb_ie, 14'b0};
    else if (w_sel_kbdr)
      w_rd_data = {8'b0, r_kbdr};
    else if (w_sel_dsr)
      w_rd_data = {~r_disp_valid, 15'b0};
    else if (w_sel_ddr)
      w_rd_data = {8'b0, r_disp_data};
  end

  assign io_bus = i_gate_mdr ? r_mdr : 16'hzzzz;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_mio_en) begin
            if (w_is_mmio || WS_ZERO) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WS_M1;
            end
          end
        end
        S_WAIT: begin
          if (!i_mio_en)
            r_state <= S_IDLE;
          else if (r_cnt == 8'd0)
            r_state <= S_DONE;
          else
            r_cnt <= r_cnt - 8'd1;
        end
        S_DONE: begin
          // Held here until mio_en drops, so one assertion yields one access.
          if (!i_mio_en)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_mar <= 16'h0000;
      r_mdr <= 16'h0000;
    end else begin
      if (i_ld_mar)
        r_mar <= io_bus;
      if (i_ld_mdr && !i_mio_en)
        r_mdr <= io_bus;
      else if (i_ld_mdr && w_rd_done)
        r_mdr <= w_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_we)
      r_ram[w_ram_idx] <= r_mdr;
  end

  // A new keystroke wins over the clearing read so no character is silently lost.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_kb_ready <= 1'b0;
      r_kbdr     <= 8'h00;
    end else begin
      if (i_kbd_valid) begin
        r_kbdr     <= i_kbd_data;
        r_kb_ready <= 1'b1;
      end else if (w_rd_done && w_sel_kbdr) begin
        r_kb_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_disp_data  <= 8'h00;
      r_disp_valid <= 1'b0;
    end else begin
      if (w_wr_done && w_sel_ddr) begin
        r_disp_data  <= r_mdr[7:0];
        r_disp_valid <= 1'b1;
      end else if (i_disp_ready) begin
        r_disp_valid <= 1'b0;
      end
    end
  end

  assign o_disp_data  = r_disp_data;
  assign o_disp_valid = r_disp_valid;

`ifdef LC3_MEM_CTRL_KBD_INT_EN
  logic r_kb_ie;
  logic r_kbd_int;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_kb_ie   <= 1'b0;
      r_kbd_int <= 1'b0;
    end else begin
      if (w_wr_done && w_sel_kbsr)
        r_kb_ie <= r_mdr[14];
      r_kbd_int <= r_kb_ready & r_kb_ie;
    end
  end

  assign w_kb_ie   = r_kb_ie;
  assign o_kbd_int = r_kbd_int;
`else
  assign w_kb_ie   = 1'b0;
  assign o_kbd_int = 1'b0;
`endif

endmodule
